// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: takes one RV32I ALU instruction, decodes it, drives the ALU and hands the result to writeback.
// Latency: the result is offered on wb_valid 4 cycles after the accept cycle when the ALU answers the cycle after alu_en.
// Backpressure: instr_ready is high only in IDLE. wb_valid/wb_rd/wb_data hold until wb_ready is sampled high.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   instr_valid/instr_ready  instruction handshake; instr is the RV32I word
//   rs1_addr/rs2_addr        register-file read addresses; rs1_data/rs2_data is the combinational read data
//   alu_en/alu_op/alu_a/alu_b  one-cycle ALU request with its operands
//   alu_valid/alu_result     ALU response
//   wb_valid/wb_ready        writeback handshake; wb_rd/wb_data is the destination register and the result
//   illegal                  one-cycle pulse when the instruction is not supported
//   timeout                  sticky abort flag. It is active only with ALU_ISSUE_TIMEOUT_EN and tied to 0 otherwise.
//
// Optional feature macro: ALU_ISSUE_TIMEOUT_EN. It aborts WAIT after TIMEOUT_CYCLES cycles with no alu_valid.

module alu_issue_ctrl #(
  parameter int WIDTH          = 32,
  parameter int OPW            = 5,
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [31:0]      instr,
  output logic [4:0]       rs1_addr,
  output logic [4:0]       rs2_addr,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  output logic             alu_en,
  output logic [OPW-1:0]   alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic             alu_valid,
  input  logic [WIDTH-1:0] alu_result,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [4:0]       wb_rd,
  output logic [WIDTH-1:0] wb_data,
  output logic             illegal,
  output logic             timeout
);

  // Reject parameter combinations that break the opcode/immediate layout at elaboration time.
  if (OPW != WIDTH - 27) begin : g_opw_chk
    $error("alu_issue_ctrl: OPW must equal WIDTH-27");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_tmo_chk
    $error("alu_issue_ctrl: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_ISSUE,
    S_WAIT,
    S_WB
  } state_t;

  state_t      state;
  logic [31:0] instr_q;

  assign rs1_addr = instr_q[19:15];
  assign rs2_addr = instr_q[24:20];

  // The decode is combinational from the latched word. It is registered into alu_* when DECODE exits.
  logic [OPW-1:0]   dec_op;
  logic [WIDTH-1:0] dec_b;
  logic             dec_ok;
  logic [6:0]       opc;
  logic [2:0]       f3;
  logic [6:0]       f7;
  logic [WIDTH-1:0] imm_i;
  logic [WIDTH-1:0] imm_sh;
  logic [WIDTH-1:0] imm_u;

  always_comb begin
    opc    = instr_q[6:0];
    f3     = instr_q[14:12];
    f7     = instr_q[31:25];
    imm_i  = {{(WIDTH-12){instr_q[31]}}, instr_q[31:20]};
    imm_sh = {{(WIDTH-5){1'b0}}, instr_q[24:20]};
    imm_u  = WIDTH'({instr_q[31:12], 12'b0});
    dec_op = '0;
    dec_b  = '0;
    dec_ok = 1'b0;
    case (opc)
      7'b0110011: begin
        dec_b  = rs2_data;
        dec_ok = 1'b1;
        case ({f7, f3})
          {7'h00, 3'b000}: dec_op = 5'b00001; // add
          {7'h20, 3'b000}: dec_op = 5'b00011; // sub
          {7'h00, 3'b111}: dec_op = 5'b01010; // and
          {7'h00, 3'b110}: dec_op = 5'b01100; // or
          {7'h00, 3'b100}: dec_op = 5'b01101; // xor
          {7'h00, 3'b001}: dec_op = 5'b01110; // sll
          {7'h00, 3'b101}: dec_op = 5'b01111; // srl
          {7'h20, 3'b101}: dec_op = 5'b10000; // sra
          {7'h01, 3'b000}: dec_op = 5'b00100; // mul
          {7'h01, 3'b100}: dec_op = 5'b01000; // div
          {7'h01, 3'b110}: dec_op = 5'b01001; // rem
          default:         dec_ok = 1'b0;
        endcase
      end
      7'b0010011: begin
        dec_b  = imm_i;
        dec_ok = 1'b1;
        case (f3)
          3'b000: dec_op = 5'b00001; // addi
          3'b111: dec_op = 5'b01010; // andi
          3'b110: dec_op = 5'b01100; // ori
          3'b100: dec_op = 5'b01101; // xori
          3'b001: begin             // slli: the shamt comes only from bits [24:20]
            dec_b  = imm_sh;
            dec_op = 5'b01110;
            dec_ok = (f7 == 7'h00);
          end
          3'b101: begin             // srli / srai are told apart by f7
            dec_b = imm_sh;
            if (f7 == 7'h00) begin
              dec_op = 5'b01111;
            end else if (f7 == 7'h20) begin
              dec_op = 5'b10000;
            end else begin
              dec_ok = 1'b0;
            end
          end
          default: dec_ok = 1'b0;   // slti / sltiu are not supported
        endcase
      end
      7'b0110111: begin             // lui: the ALU passes B through
        dec_b  = imm_u;
        dec_op = 5'b11000;
        dec_ok = 1'b1;
      end
      default: dec_ok = 1'b0;
    endcase
  end

`ifdef ALU_ISSUE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      instr_q     <= '0;
      instr_ready <= 1'b1;
      alu_en      <= 1'b0;
      alu_op      <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      wb_valid    <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
      illegal     <= 1'b0;
`ifdef ALU_ISSUE_TIMEOUT_EN
      timeout     <= 1'b0;
      wait_cnt    <= '0;
`endif
    end else begin
      alu_en  <= 1'b0;
      illegal <= 1'b0;
      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            instr_q     <= instr;
            instr_ready <= 1'b0;
            state       <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (dec_ok) begin
            alu_op <= dec_op;
            alu_a  <= rs1_data;
            alu_b  <= dec_b;
            alu_en <= 1'b1;     // alu_en is high for exactly the ISSUE cycle
            state  <= S_ISSUE;
          end else begin
            illegal     <= 1'b1;
            instr_ready <= 1'b1;
            state       <= S_IDLE;
          end
        end
        S_ISSUE: begin
`ifdef ALU_ISSUE_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (alu_valid) begin
            wb_data <= alu_result;
            if (instr_q[11:7] == 5'd0) begin
              // The destination is x0, so the result is dropped and no writeback is offered.
              instr_ready <= 1'b1;
              state       <= S_IDLE;
            end else begin
              wb_rd    <= instr_q[11:7];
              wb_valid <= 1'b1;
              state    <= S_WB;
            end
          end
`ifdef ALU_ISSUE_TIMEOUT_EN
          else if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            timeout     <= 1'b1;
            instr_ready <= 1'b1;
            state       <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
`endif
        end
        S_WB: begin
          if (wb_ready) begin
            wb_valid    <= 1'b0;
            instr_ready <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: begin
          instr_ready <= 1'b1;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: scoreboard bench for alu_issue_ctrl with a register-file model and a responding ALU model.
// Latency: the bench expects wb_valid 4 cycles after the accept cycle.
// Backpressure: wb_ready is normally held high and is dropped for one hold sequence.

module tb_alu_issue_ctrl;

  localparam int WIDTH = 32;
  localparam int OPW   = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             instr_valid;
  logic             instr_ready;
  logic [31:0]      instr;
  logic [4:0]       rs1_addr, rs2_addr;
  logic [WIDTH-1:0] rs1_data, rs2_data;
  logic             alu_en;
  logic [OPW-1:0]   alu_op;
  logic [WIDTH-1:0] alu_a, alu_b;
  logic             alu_valid;
  logic [WIDTH-1:0] alu_result;
  logic             wb_valid;
  logic             wb_ready;
  logic [4:0]       wb_rd;
  logic [WIDTH-1:0] wb_data;
  logic             illegal;
  logic             timeout;

  alu_issue_ctrl #(.WIDTH(WIDTH), .OPW(OPW), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .alu_en(alu_en), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_valid(alu_valid), .alu_result(alu_result),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .illegal(illegal), .timeout(timeout)
  );

  initial forever #5 clk = ~clk;

  logic [WIDTH-1:0] regs [32];
  assign rs1_data = (rs1_addr == 5'd0) ? '0 : regs[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0) ? '0 : regs[rs2_addr];

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int acc_cyc = 0;
  int en_cnt = 0;
  int wb_cnt = 0;
  bit alu_resp = 1'b1;
  int alu_delay = 0;
  bit wbv_prev = 1'b0;

  logic [68:0] q_alu [$];   // {op, a, b}
  logic [36:0] q_wb  [$];   // {rd, data}

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                      input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_t(input logic [11:0] imm, input logic [4:0] rs1,
                                      input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] u_t(input logic [19:0] imm, input logic [4:0] rd);
    return {imm, rd, 7'b0110111};
  endfunction

  function automatic logic [31:0] alu_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      5'b00001: return a + b;
      5'b00011: return a - b;
      5'b01010: return a & b;
      5'b01100: return a | b;
      5'b01101: return a ^ b;
      5'b01110: return a << b[4:0];
      5'b01111: return a >> b[4:0];
      5'b10000: return $unsigned($signed(a) >>> b[4:0]);
      5'b00100: return a * b;
      5'b11000: return b;
      default:  return 32'hDEADBEEF;
    endcase
  endfunction

  initial forever @(posedge clk) cyc++;

  initial forever begin
    @(negedge clk);
    if (alu_en) en_cnt++;
  end

  // ALU model: it answers alu_en after 1+alu_delay edges and checks the request against the scoreboard.
  initial begin
    logic [68:0] e;
    logic [31:0] res;
    alu_valid  = 1'b0;
    alu_result = '0;
    forever begin
      @(negedge clk);
      if (alu_en) begin
        chk("alu_q_nonempty", q_alu.size() > 0, 1);
        if (q_alu.size() > 0) begin
          e = q_alu.pop_front();
          chk("alu_op", alu_op, e[68:64]);
          chk("alu_a", alu_a, e[63:32]);
          chk("alu_b", alu_b, e[31:0]);
        end
        if (alu_resp) begin
          res = alu_model(alu_op, alu_a, alu_b);
          repeat (1 + alu_delay) @(posedge clk);
          #1 alu_valid = 1'b1;
          alu_result = res;
          @(posedge clk);
          #1 alu_valid = 1'b0;
          alu_result = '0;
        end
      end
    end
  end

  // Writeback monitor: it checks the result latency and pops the expected {rd, data} on each handshake.
  initial begin
    logic [36:0] e;
    forever begin
      @(negedge clk);
      if (wb_valid && !wbv_prev) chk("wb_latency", cyc - acc_cyc, 4);
      wbv_prev = wb_valid;
      if (wb_valid && wb_ready) begin
        wb_cnt++;
        chk("wb_q_nonempty", q_wb.size() > 0, 1);
        if (q_wb.size() > 0) begin
          e = q_wb.pop_front();
          chk("wb_rd", wb_rd, e[36:32]);
          chk("wb_data", wb_data, e[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [31:0] w);
    @(posedge clk);
    #1 instr_valid = 1'b1;
    instr = w;
    @(negedge clk);
    chk("accept_ready", instr_ready, 1);
    acc_cyc = cyc;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    instr = '0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!instr_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("ready_back", instr_ready, 1);
  endtask

  task automatic wait_en();
    int n;
    n = 0;
    @(negedge clk);
    while (!alu_en && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("en_seen", alu_en, 1);
  endtask

  task automatic run(input logic [31:0] w, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] rd, input logic [31:0] data);
    int e0, w0;
    e0 = en_cnt;
    w0 = wb_cnt;
    q_alu.push_back({op, a, b});
    if (rd != 5'd0) q_wb.push_back({rd, data});
    send(w);
    wait_idle();
    chk("en_pulses", en_cnt - e0, 1);
    chk("wb_count", wb_cnt - w0, (rd != 5'd0) ? 1 : 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ctl"}, {instr_ready, alu_en, illegal, timeout, wb_valid}, 5'b10000);
    chk({tag, "_alu"}, {alu_op, alu_a, alu_b}, '0);
    chk({tag, "_wb"}, {wb_rd, wb_data}, '0);
  endtask

  initial begin
    int e0, w0, n;
    rst = 1'b1;
    instr_valid = 1'b0;
    instr = '0;
    wb_ready = 1'b1;
    for (int i = 0; i < 32; i++) regs[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset("rst");
    @(posedge clk);
    #1 rst = 1'b0;

    // add x3,x1,x2
    regs[1] = 32'd5; regs[2] = 32'd7;
    run(r_t(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 5'b00001, 32'd5, 32'd7, 5'd3, 32'd12);
    // addi x4,x1,-1
    regs[1] = 32'd0;
    run(i_t(12'hFFF, 5'd1, 3'b000, 5'd4), 5'b00001, 32'd0, 32'hFFFFFFFF, 5'd4, 32'hFFFFFFFF);
    // lui x5,0xABCDE: the rs1 field overlaps the immediate bits and selects x27
    regs[27] = 32'h1234;
    run(u_t(20'hABCDE, 5'd5), 5'b11000, 32'h1234, 32'hABCDE000, 5'd5, 32'hABCDE000);

    // sub x1,x2,x3 with wb_ready held low for 5 WB cycles
    regs[2] = 32'd20; regs[3] = 32'd6;
    @(posedge clk);
    #1 wb_ready = 1'b0;
    e0 = en_cnt;
    q_alu.push_back({5'b00011, 32'd20, 32'd6});
    q_wb.push_back({5'd1, 32'd14});
    send(r_t(7'h20, 5'd3, 5'd2, 3'b000, 5'd1));
    n = 0;
    @(negedge clk);
    while (!wb_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("wb_seen", wb_valid, 1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("wb_hold", {wb_valid, instr_ready, wb_rd, wb_data, alu_op, alu_a, alu_b},
          {1'b1, 1'b0, 5'd1, 32'd14, 5'b00011, 32'd20, 32'd6});
    end
    @(posedge clk);
    #1 wb_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("idle_after_wb", {instr_ready, wb_valid}, 2'b10);
    chk("sub_en_pulses", en_cnt - e0, 1);

    // slt is unsupported: expect an illegal pulse and no alu_en
    e0 = en_cnt;
    send(r_t(7'h00, 5'd2, 5'd1, 3'b010, 5'd6));
    @(negedge clk);
    @(negedge clk);
    chk("illegal_pulse", {illegal, instr_ready}, 2'b11);
    @(negedge clk);
    chk("illegal_clear", illegal, 0);
    chk("illegal_no_en", en_cnt - e0, 0);

    // add x0,x1,x2 drives the ALU but is never written back
    regs[1] = 32'd5; regs[2] = 32'd7;
    run(r_t(7'h00, 5'd2, 5'd1, 3'b000, 5'd0), 5'b00001, 32'd5, 32'd7, 5'd0, 32'd0);

    // srai x7,x1,4
    regs[1] = 32'h80000000;
    run(i_t({7'h20, 5'd4}, 5'd1, 3'b101, 5'd7), 5'b10000, 32'h80000000, 32'd4, 5'd7, 32'hF8000000);
    // xor x8,x1,x2
    regs[1] = 32'hF0F0F0F0; regs[2] = 32'h0FF00FF0;
    run(r_t(7'h00, 5'd2, 5'd1, 3'b100, 5'd8), 5'b01101, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd8, 32'hFF00FF00);
    // mul x9,x1,x2
    regs[1] = 32'd6; regs[2] = 32'd7;
    run(r_t(7'h01, 5'd2, 5'd1, 3'b000, 5'd9), 5'b00100, 32'd6, 32'd7, 5'd9, 32'd42);
    // andi x11,x1,0xF0
    regs[1] = 32'hFF;
    run(i_t(12'h0F0, 5'd1, 3'b111, 5'd11), 5'b01010, 32'hFF, 32'hF0, 5'd11, 32'hF0);

    // reset while in WAIT, with the ALU answering only after the reset
    regs[1] = 32'd5; regs[2] = 32'd7;
    alu_delay = 3;
    w0 = wb_cnt;
    q_alu.push_back({5'b00001, 32'd5, 32'd7});
    send(r_t(7'h00, 5'd2, 5'd1, 3'b000, 5'd9));
    wait_en();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_reset("rst_wait");
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("rst_no_wb", wb_cnt - w0, 0);
    chk("rst_idle", {instr_ready, wb_valid}, 2'b10);
    alu_delay = 0;

    // the controller must still work normally after the reset
    run(u_t(20'h00001, 5'd12), 5'b11000, 32'd0, 32'h00001000, 5'd12, 32'h00001000);

`ifdef ALU_ISSUE_TIMEOUT_EN
    // ALU never answers: expect the abort after 8 WAIT cycles
    alu_resp = 1'b0;
    w0 = wb_cnt;
    q_alu.push_back({5'b00001, 32'd5, 32'd7});
    send(r_t(7'h00, 5'd2, 5'd1, 3'b000, 5'd13));
    wait_en();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("wait_no_timeout", {timeout, instr_ready}, 2'b00);
    end
    @(negedge clk);
    chk("timeout_set", {timeout, instr_ready, wb_valid}, 3'b110);
    repeat (3) @(negedge clk);
    chk("timeout_sticky", {timeout, wb_cnt - w0}, {1'b1, 32'd0});
    alu_resp = 1'b1;
`endif

    repeat (3) @(negedge clk);
    chk("q_drained", q_alu.size() + q_wb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
